// File: rtl/timer_prog_seq_if.sv
// Requester-side handshake and timer write bus of the timer programming sequencer.
// The sequencer uses the slave modport; the system/requester side uses master.
interface timer_prog_seq_if;
  logic [1:0]  req;
  logic [2:0]  mode0;
  logic [15:0] cnt0;
  logic [2:0]  mode1;
  logic [15:0] cnt1;
  logic [1:0]  ack;
  logic        err;
  logic        busy;
  logic        gnt_id;
  logic        cs;
  logic        wr;
  logic        a0;
  logic [15:0] dout;

  modport master (
    output req, mode0, cnt0, mode1, cnt1,
    input  ack, err, busy, gnt_id, cs, wr, a0, dout
  );

  modport slave (
    input  req, mode0, cnt0, mode1, cnt1,
    output ack, err, busy, gnt_id, cs, wr, a0, dout
  );
endinterface

// File: rtl/timer_prog_seq.sv
// Shares one 8253-style timer write port between two requesters: mode write, count write, quiet gap.
// Build option: define TIMER_SEQ_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module timer_prog_seq #(
  parameter int GAP = 2
) (
  input  logic           clk,
  input  logic           reset,
  timer_prog_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_MODE = 2'd1,
    WR_CNT  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(GAP - 1);

  // Modes 6 and 7 do not exist on the timer and are rejected without a bus access.
  function automatic logic mode_illegal(input logic [2:0] m);
    return (m >= 3'd6);
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  hold_cnt_r, hold_cnt_s;
  logic [2:0]  mode_r, mode_s;
  logic [15:0] cnt_r, cnt_s;
  logic        gnt_r, gnt_s;
  logic        win_s;
  logic [2:0]  win_mode_s;
  logic [15:0] win_cnt_s;
  logic [1:0]  ack_r, ack_s;
  logic        err_r, err_s;
  logic        busy_r, busy_s;
  logic        cs_r, cs_s;
  logic        wr_r, wr_s;
  logic        a0_r, a0_s;
  logic [15:0] dout_r, dout_s;
`ifdef TIMER_SEQ_RR_EN
  logic        last_r, last_s;
`endif

  // Winner selection and the winner's mode/count
  always_comb begin
`ifdef TIMER_SEQ_RR_EN
    if (bus.req == 2'b11) begin
      win_s = ~last_r;
    end else begin
      win_s = bus.req[1];
    end
`else
    win_s = ~bus.req[0];
`endif
    if (win_s) begin
      win_mode_s = bus.mode1;
      win_cnt_s  = bus.cnt1;
    end else begin
      win_mode_s = bus.mode0;
      win_cnt_s  = bus.cnt0;
    end
  end

  // Next state, latched request, and next values of the registered outputs
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    mode_s     = mode_r;
    cnt_s      = cnt_r;
    gnt_s      = gnt_r;
    ack_s      = 2'b00;
    err_s      = 1'b0;
`ifdef TIMER_SEQ_RR_EN
    last_s     = last_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.req != 2'b00) begin
          mode_s = win_mode_s;
          cnt_s  = win_cnt_s;
          gnt_s  = win_s;
`ifdef TIMER_SEQ_RR_EN
          last_s = win_s;
`endif
          if (mode_illegal(win_mode_s)) begin
            ack_s = win_s ? 2'b10 : 2'b01;
            err_s = 1'b1;
          end else begin
            state_s = WR_MODE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR_MODE: state_s = WR_CNT;
      WR_CNT: begin
        state_s    = HOLD;
        hold_cnt_s = 4'd0;
        ack_s      = gnt_r ? 2'b10 : 2'b01;
      end
      HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_s    = IDLE;
          hold_cnt_s = 4'd0;
        end else begin
          hold_cnt_s = hold_cnt_r + 4'd1;
        end
      end
      default: state_s = IDLE;
    endcase

    // Bus values follow the state being entered so they appear with it.
    cs_s   = 1'b0;
    wr_s   = 1'b0;
    a0_s   = 1'b0;
    dout_s = 16'h0000;
    case (state_s)
      WR_MODE: begin
        cs_s   = 1'b1;
        wr_s   = 1'b1;
        a0_s   = 1'b1;
        dout_s = {13'd0, mode_s};
      end
      WR_CNT: begin
        cs_s   = 1'b1;
        wr_s   = 1'b1;
        a0_s   = 1'b0;
        dout_s = cnt_s;
      end
      default: begin
        cs_s   = 1'b0;
        wr_s   = 1'b0;
        a0_s   = 1'b0;
        dout_s = 16'h0000;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= 4'd0;
      mode_r     <= 3'd0;
      cnt_r      <= 16'h0000;
      gnt_r      <= 1'b0;
      ack_r      <= 2'b00;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      cs_r       <= 1'b0;
      wr_r       <= 1'b0;
      a0_r       <= 1'b0;
      dout_r     <= 16'h0000;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      mode_r     <= mode_s;
      cnt_r      <= cnt_s;
      gnt_r      <= gnt_s;
      ack_r      <= ack_s;
      err_r      <= err_s;
      busy_r     <= busy_s;
      cs_r       <= cs_s;
      wr_r       <= wr_s;
      a0_r       <= a0_s;
      dout_r     <= dout_s;
    end
  end

`ifdef TIMER_SEQ_RR_EN
  // Round-robin pointer: last served requester, starts at 1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= 1'b1;
    end else begin
      last_r <= last_s;
    end
  end
`endif

  assign bus.ack    = ack_r;
  assign bus.err    = err_r;
  assign bus.busy   = busy_r;
  assign bus.gnt_id = gnt_r;
  assign bus.cs     = cs_r;
  assign bus.wr     = wr_r;
  assign bus.a0     = a0_r;
  assign bus.dout   = dout_r;

endmodule
